// File: rtl/sub4bit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sub4bit_pkg
// Purpose  : Shared state encoding and default width for the serial subtractor.
// Revision : 1.0 - initial release
// ============================================================================
package sub4bit_pkg;

    localparam int c_DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : sub4bit_pkg
`default_nettype wire

// File: rtl/full_sub00.sv
`default_nettype none
// ============================================================================
// Module   : full_sub00
// Purpose  : One-bit full subtractor, d = a - b - bin with borrow out.
// Revision : 1.0 - initial release
// ============================================================================
module full_sub00 (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic w_axb;

    assign w_axb = a ^ b;
    assign d     = w_axb ^ bin;
    assign bout  = (~a & b) | (~w_axb & bin);

endmodule : full_sub00
`default_nettype wire

// File: rtl/sub4bit_serial00.sv
`default_nettype none
// ============================================================================
// Module   : sub4bit_serial00
// Purpose  : Bit-serial LSB-first subtractor, Ai - Bi over WIDTH clock cycles.
// Revision : 1.0 - initial release
// ============================================================================
module sub4bit_serial00
    import sub4bit_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic             clk0,
    input  logic             reset0,
    input  logic [WIDTH-1:0] Ai,
    input  logic [WIDTH-1:0] Bi,
    input  logic             start0,
    output logic [WIDTH-1:0] LED,
    output logic             Bo,
    output logic             busy0,
    output logic             done0
);

    localparam int                 c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_res;
    logic [WIDTH-1:0]   r_led;
    logic               r_bo;
    logic               r_br;
    logic [c_CNT_W-1:0] r_cnt;
    logic               w_last;
    logic               w_d;
    logic               w_bout;
    logic [WIDTH-1:0]   w_res_nxt;

    full_sub00 u_full_sub (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .bin  (r_br),
        .d    (w_d),
        .bout (w_bout)
    );

    assign w_last    = (r_cnt == c_LAST);
    assign w_res_nxt = {w_d, r_res[WIDTH-1:1]};

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (start0) w_state_nxt = SHIFT;
            SHIFT:   if (w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk0) begin
        if (reset0) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Outputs only move on the final shift edge, so they hold between operations.
    always_ff @(posedge clk0) begin
        if (reset0) begin
            r_a   <= '0;
            r_b   <= '0;
            r_res <= '0;
            r_led <= '0;
            r_bo  <= 1'b0;
            r_br  <= 1'b0;
            r_cnt <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (start0) begin
                        r_a   <= Ai;
                        r_b   <= Bi;
                        r_br  <= 1'b0;
                        r_cnt <= '0;
                    end
                end
                SHIFT: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_res <= w_res_nxt;
                    r_br  <= w_bout;
                    r_cnt <= w_last ? '0 : r_cnt + c_CNT_W'(1);
                    if (w_last) begin
                        r_led <= w_res_nxt;
                        r_bo  <= w_bout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign LED   = r_led;
    assign Bo    = r_bo;
    assign busy0 = (r_state != IDLE);
    assign done0 = (r_state == DONE);

endmodule : sub4bit_serial00
`default_nettype wire

// File: tb/tb_sub4bit_serial00.sv
`default_nettype none
// ============================================================================
// Module   : tb_sub4bit_serial00
// Purpose  : Scoreboard bench for the bit-serial subtractor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sub4bit_serial00;

    localparam int WIDTH = 4;

    logic             clk0 = 1'b0;
    logic             reset0;
    logic [WIDTH-1:0] Ai;
    logic [WIDTH-1:0] Bi;
    logic             start0;
    logic [WIDTH-1:0] LED;
    logic             Bo;
    logic             busy0;
    logic             done0;

    int          n_vectors = 0;
    int          n_miscompares = 0;
    logic [WIDTH:0] sb_q[$];

    sub4bit_serial00 #(.WIDTH(WIDTH)) dut (
        .clk0   (clk0),
        .reset0 (reset0),
        .Ai     (Ai),
        .Bi     (Bi),
        .start0 (start0),
        .LED    (LED),
        .Bo     (Bo),
        .busy0  (busy0),
        .done0  (done0)
    );

    always #5 clk0 = ~clk0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vectors++;
        if (obs !== exp) begin
            n_miscompares++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk0);
            #1;
        end
    endtask

    // Every done0 pulse consumes exactly one scoreboard entry.
    always begin
        @(posedge clk0);
        #1;
        if (done0) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'(done0), 32'd0);
            end else begin
                logic [WIDTH:0] e;
                e = sb_q.pop_front();
                check("diff", 32'({Bo, LED}), 32'(e));
            end
        end
    end

    function automatic logic [WIDTH:0] ref_sub(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return {1'b0, a} - {1'b0, b};
    endfunction

    // One start pulse; checks latency, pulse width and hold of the result.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH:0] exp);
        Ai = a;
        Bi = b;
        start0 = 1'b1;
        sb_q.push_back(exp);
        tick();
        start0 = 1'b0;
        check("busy_after_start", 32'(busy0), 32'd1);
        tick(WIDTH - 1);
        check("done_early", 32'(done0), 32'd0);
        tick();
        check("done_latency", 32'(done0), 32'd1);
        tick();
        check("done_clear", 32'(done0), 32'd0);
        check("busy_idle", 32'(busy0), 32'd0);
        tick();
        check("led_hold", 32'({Bo, LED}), 32'(exp));
    endtask

    initial begin
        reset0 = 1'b1;
        start0 = 1'b0;
        Ai = '0;
        Bi = '0;
        tick(2);
        check("rst_led", 32'(LED), 32'd0);
        check("rst_bo", 32'(Bo), 32'd0);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_done", 32'(done0), 32'd0);

        // Start accepted on the very first edge after reset release.
        reset0 = 1'b0;
        run_op(4'b0111, 4'b0011, 5'b0_0100);
        run_op(4'b0011, 4'b0111, 5'b1_1100);
        run_op(4'b1111, 4'b1111, 5'b0_0000);
        run_op(4'b0000, 4'b0001, 5'b1_1111);

        // Start during SHIFT is ignored and operand changes do not leak in.
        Ai = 4'b0101;
        Bi = 4'b0001;
        start0 = 1'b1;
        sb_q.push_back(5'b0_0100);
        tick();
        Ai = 4'b1111;
        Bi = 4'b1111;
        tick(2);
        start0 = 1'b0;
        tick(WIDTH - 2);
        check("ignore_done", 32'(done0), 32'd1);
        tick();
        check("ignore_single", 32'(done0), 32'd0);
        tick(WIDTH + 2);
        check("ignore_idle", 32'(busy0), 32'd0);

        // Reset on the second SHIFT edge aborts without a done pulse.
        Ai = 4'b1000;
        Bi = 4'b0001;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        tick();
        reset0 = 1'b1;
        tick();
        reset0 = 1'b0;
        check("abort_busy", 32'(busy0), 32'd0);
        check("abort_led", 32'(LED), 32'd0);
        check("abort_bo", 32'(Bo), 32'd0);
        check("abort_done", 32'(done0), 32'd0);
        tick(WIDTH + 2);
        check("abort_quiet", 32'(busy0), 32'd0);

        // Held start: a new operation every WIDTH+2 cycles.
        Ai = 4'b1010;
        Bi = 4'b0101;
        start0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sb_q.push_back(5'b0_0101);
            tick();
            check("held_busy", 32'(busy0), 32'd1);
            if (i == 2) start0 = 1'b0;
            tick(WIDTH);
            check("held_done", 32'(done0), 32'd1);
            tick();
            check("held_done_clr", 32'(done0), 32'd0);
            check("held_idle", 32'(busy0), 32'd0);
        end
        tick(2);

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_op(4'(a), 4'(b), ref_sub(4'(a), 4'(b)));
            end
        end

        tick(3);
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule : tb_sub4bit_serial00
`default_nettype wire

// File: doc/sub4bit_serial00.md
SUB4BIT_SERIAL00 -- requirements
Module: sub4bit_serial00

Interface
REQ-001 Parameter: WIDTH, default 4, operand and result width in bits.
REQ-002 Port: clk0  in  1  single system clock; all state changes on its rising edge.
REQ-003 Port: reset0  in  1  synchronous, active-high reset.
REQ-004 Port: Ai  in  WIDTH  minuend, sampled only when a start is accepted.
REQ-005 Port: Bi  in  WIDTH  subtrahend, sampled only when a start is accepted.
REQ-006 Port: start0  in  1  request to begin a subtraction; level-sampled each edge.
REQ-007 Port: LED  out  WIDTH  registered difference (Ai - Bi) mod 2^WIDTH of the last completed operation.
REQ-008 Port: Bo  out  1  registered borrow-out of the last completed operation (1 when Ai < Bi unsigned).
REQ-009 Port: busy0  out  1  high whenever the FSM is not in IDLE.
REQ-010 Port: done0  out  1  one-cycle pulse marking LED/Bo update.

Function
REQ-011 FSM states SHALL be IDLE, SHIFT and DONE.
REQ-012 In IDLE with start0=1 at an edge, the block SHALL latch Ai and Bi into operand shift registers, clear the internal borrow and bit counter, and enter SHIFT.
REQ-013 In IDLE with start0=0, the block SHALL remain in IDLE with all registers unchanged.
REQ-014 Each SHIFT edge SHALL process one bit LSB-first: d = a0 xor b0 xor br; br_next = (not a0 and b0) or (not (a0 xor b0) and br).
REQ-015 Each SHIFT edge SHALL shift both operand registers right one place and shift d into the MSB of the result shift register.
REQ-016 The bit counter SHALL increment per SHIFT edge and wrap to 0; after exactly WIDTH SHIFT edges the FSM SHALL enter DONE.
REQ-017 On the edge entering DONE, LED SHALL load the full result, Bo SHALL load the final borrow, and done0 SHALL be set.
REQ-018 Latency: with start accepted at edge k, done0, LED and Bo SHALL be valid after edge k+WIDTH; done0 SHALL clear after edge k+WIDTH+1.
REQ-019 DONE SHALL last exactly one cycle and return to IDLE unconditionally.
REQ-020 start0 SHALL be ignored in SHIFT and DONE; no queuing; Ai/Bi changes during SHIFT SHALL not affect the result.
REQ-021 With start0 held high continuously, a new operation SHALL start every WIDTH+2 cycles.
REQ-022 LED and Bo SHALL hold their values between completions.

Reset
REQ-023 reset0=1 at an edge SHALL force IDLE, and clear LED, Bo, busy0, done0, counter, borrow and all shift registers to 0.
REQ-024 reset0 SHALL take priority over start0 and SHALL abort an operation in SHIFT or DONE without producing done0.
REQ-025 The first start0 after reset0 deasserts SHALL be accepted at the first edge where reset0=0.

Structure
REQ-026 A shared package sub4bit_pkg SHALL hold the state enumeration (IDLE, SHIFT, DONE) and the default width constant.
REQ-027 The one-bit difference/borrow logic SHALL be a sub-module full_sub00 (ports a, b, bin, d, bout).
REQ-028 The FSM, counter and shift registers SHALL live in sub4bit_serial00; no combinational path from Ai/Bi to LED.

Verification
REQ-029 Ai=0111, Bi=0011, start pulse -> after WIDTH edges LED=0100, Bo=0, done0 high one cycle.
REQ-030 Ai=0011, Bi=0111 -> LED=1100, Bo=1; Ai=1111, Bi=1111 -> LED=0000, Bo=0; Ai=0000, Bi=0001 -> LED=1111, Bo=1.
REQ-031 start pulse with Ai=0101, Bi=0001, then Ai=1111, Bi=1111 and start0=1 on the next two edges -> LED=0100, single done0, second start ignored.
REQ-032 reset0 asserted on second SHIFT edge of Ai=1000, Bi=0001 -> next cycle busy0=0, LED=0000, Bo=0, no done0.
REQ-033 start0 held high 3 operations, Ai=1010, Bi=0101 -> done0 pulses every 6 cycles (WIDTH=4), LED=0101 each time.
REQ-034 Exhaustive 256 operand pairs -> {Bo,LED} equals (Ai - Bi) in 5-bit two's complement, checked against a reference model.
